draw_rect_ctl: RTL and testbench
================================

DRAW_RECT_CTL -- requirements
Module: draw_rect_ctl

Interface
REQ-001 The module SHALL have parameter x_fix_position_player_1, default 32, meaning the left x of the player-1 paddle in pixels.
REQ-002 The module SHALL have parameter x_fix_position_player_2, default 976, meaning the left x of the player-2 paddle in pixels.
REQ-003 The module SHALL have parameter width, default 16, meaning the paddle width in pixels.
REQ-004 The module SHALL have parameter height, default 128, meaning the paddle height in pixels.
REQ-005 The module SHALL have parameter color, default 12'hFFF, meaning the paddle RGB444 colour.
REQ-006 clk65MHz  in  1  the single clock (65 MHz, 1024x768 timing).
REQ-007 rst  in  1  reset, synchronous and active-high.
REQ-008 mouse_ypos  in  12  local mouse y coordinate.
REQ-009 screen_idle  in  1  idle/menu screen active.
REQ-010 screen_single  in  1  single-player game active.
REQ-011 input_pos  in  10  player-2 target y (remote player or AI target).
REQ-012 output_pos  out  10  current player-1 paddle y, for the remote side.
REQ-013 draw_bg_if  vga_if.in  -  upstream timing plus rgb: hcount[10:0], hsync, hblnk, vcount[10:0], vsync, vblnk, rgb[11:0].
REQ-014 draw_rect_if  vga_if.out  -  same fields, delayed and with paddles overlaid.

Function
REQ-015 Mode SHALL be decoded as: IDLE when screen_idle=1 (priority over screen_single); SINGLE when screen_idle=0 and screen_single=1; MULTI when both are 0.
REQ-016 Paddle positions SHALL update only once per frame, on the cycle where draw_bg_if.vblnk rises (0 -> 1), to avoid tearing.
REQ-017 At each update, p1_y SHALL become min(mouse_ypos, 768-height), truncated to 10 bits after clamping.
REQ-018 At each update in MULTI, p2_y SHALL become min(input_pos, 768-height).
REQ-019 At each update in SINGLE, p2_y SHALL move toward min(input_pos, 768-height) by at most 2 pixels per frame; it SHALL not overshoot, and SHALL stay put when equal.
REQ-020 In IDLE, p1_y and p2_y SHALL hold their values.
REQ-021 output_pos SHALL equal the registered p1_y.
REQ-022 All draw_rect_if timing fields (hcount, hsync, hblnk, vcount, vsync, vblnk) SHALL equal the draw_bg_if fields delayed by exactly 1 clock.
REQ-023 draw_rect_if.rgb SHALL equal color, one clock later, when the mode is not IDLE, both blanks are 0, and the pixel is inside a paddle; otherwise it SHALL equal draw_bg_if.rgb delayed by 1 clock.
REQ-024 For paddle 1, "inside" SHALL mean x_fix_position_player_1 <= hcount < x_fix_position_player_1+width and p1_y <= vcount < p1_y+height; paddle 2 SHALL use the same rule with x_fix_position_player_2 and p2_y.
REQ-025 Comparisons SHALL use at least 12-bit unsigned arithmetic, so x+width and y+height never wrap.
REQ-026 width=0 or height=0 SHALL result in no paddle pixels ever drawn; timing pass-through SHALL be unaffected.
REQ-027 A mode change SHALL affect rgb overlay from the next clock and positions from the next vblnk rising edge.

Reset
REQ-028 While rst=1, all draw_rect_if outputs SHALL be 0 on the next clock edge.
REQ-029 While rst=1, p1_y and p2_y SHALL be set to (768-height)/2 (320 at defaults) and output_pos SHALL be 320.
REQ-030 A rst asserted mid-frame SHALL take effect on the next clock edge; normal operation SHALL resume on the first clock after release, with positions next updating at the following vblnk rise.

Verification
REQ-031 Assert rst for 2 clocks -> all draw_rect_if outputs are 0 and output_pos is 320.
REQ-032 IDLE mode with mouse_ypos=100 over 2 frames -> rgb equals the 1-cycle-delayed background everywhere, and output_pos stays 320.
REQ-033 SINGLE mode, mouse_ypos=100 -> after the next vblnk rise output_pos is 100, and pixel (40,150) is color while pixel (40,99) is background.
REQ-034 mouse_ypos=700 -> after one frame output_pos is 640 (clamped), and the paddle covers vcount 640..767.
REQ-035 MULTI mode, input_pos=400 -> after one frame p2 is drawn at x 976..991, y 400..527; in SINGLE mode from 320 with input_pos=400, p2_y instead reaches 322, 324, ... one step per frame, up to 400.
REQ-036 screen_idle and screen_single both asserted -> IDLE behaviour: no overlay is drawn and positions are frozen.

Source files
------------

// File: rtl/draw_rect_ctl_if.sv
// VGA pixel stream: timing counters, sync/blank strobes and RGB444 colour.
interface vga_if;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [11:0] rgb;

    modport in  (input  hcount, hsync, hblnk, vcount, vsync, vblnk, rgb);
    modport out (output hcount, hsync, hblnk, vcount, vsync, vblnk, rgb);
endinterface

// File: rtl/draw_rect_ctl.sv
// Pong paddle controller: per-frame paddle position update and paddle overlay
// onto the background pixel stream with a one-clock pipeline delay.
module draw_rect_ctl #(
    parameter int unsigned x_fix_position_player_1 = 32,
    parameter int unsigned x_fix_position_player_2 = 976,
    parameter int unsigned width                   = 16,
    parameter int unsigned height                  = 128,
    parameter logic [11:0] color                   = 12'hFFF
) (
    input  logic        clk65MHz,
    input  logic        rst,
    input  logic [11:0] mouse_ypos,
    input  logic        screen_idle,
    input  logic        screen_single,
    input  logic [9:0]  input_pos,
    output logic [9:0]  output_pos,
    vga_if.in           draw_bg_if,
    vga_if.out          draw_rect_if
);

    localparam int unsigned SCREEN_H = 768;
    localparam int unsigned MAX_Y    = (height >= SCREEN_H) ? 0 : SCREEN_H - height;
    localparam int unsigned RST_Y    = MAX_Y / 2;
    localparam int unsigned CW       = 13;
    localparam int unsigned AI_STEP  = 2;

    typedef enum logic [1:0] {
        MODE_IDLE,
        MODE_SINGLE,
        MODE_MULTI
    } mode_e;

    mode_e       mode_c;
    logic        vblnk_rise_c;
    logic [9:0]  p1_tgt_c, p2_tgt_c, p2_step_c, p2_diff_c;
    logic        in_p1_c, in_p2_c;
    logic [CW-1:0] hc_c, vc_c;

    logic [9:0]  p1_y_q, p1_y_d;
    logic [9:0]  p2_y_q, p2_y_d;
    logic [10:0] hcount_q, hcount_d;
    logic [10:0] vcount_q, vcount_d;
    logic        hsync_q, hsync_d;
    logic        hblnk_q, hblnk_d;
    logic        vsync_q, vsync_d;
    logic        vblnk_q, vblnk_d;
    logic [11:0] rgb_q, rgb_d;

    // Mode decode, clamped targets and the rate-limited AI step toward target.
    always_comb begin
        mode_c = MODE_MULTI;
        if (screen_idle)        mode_c = MODE_IDLE;
        else if (screen_single) mode_c = MODE_SINGLE;

        vblnk_rise_c = draw_bg_if.vblnk & ~vblnk_q;

        p1_tgt_c = (mouse_ypos > 12'(MAX_Y)) ? 10'(MAX_Y) : mouse_ypos[9:0];
        p2_tgt_c = ({2'b00, input_pos} > 12'(MAX_Y)) ? 10'(MAX_Y) : input_pos;

        p2_diff_c = 10'd0;
        p2_step_c = p2_y_q;
        if (p2_y_q < p2_tgt_c) begin
            p2_diff_c = p2_tgt_c - p2_y_q;
            p2_step_c = p2_y_q + ((p2_diff_c > 10'(AI_STEP)) ? 10'(AI_STEP) : p2_diff_c);
        end else if (p2_y_q > p2_tgt_c) begin
            p2_diff_c = p2_y_q - p2_tgt_c;
            p2_step_c = p2_y_q - ((p2_diff_c > 10'(AI_STEP)) ? 10'(AI_STEP) : p2_diff_c);
        end
    end

    // Paddle hit test in widened arithmetic so x+width / y+height cannot wrap.
    always_comb begin
        hc_c = CW'(draw_bg_if.hcount);
        vc_c = CW'(draw_bg_if.vcount);
        in_p1_c = (hc_c >= CW'(x_fix_position_player_1)) &&
                  (hc_c <  CW'(x_fix_position_player_1 + width)) &&
                  (vc_c >= CW'(p1_y_q)) &&
                  (vc_c <  CW'(p1_y_q) + CW'(height));
        in_p2_c = (hc_c >= CW'(x_fix_position_player_2)) &&
                  (hc_c <  CW'(x_fix_position_player_2 + width)) &&
                  (vc_c >= CW'(p2_y_q)) &&
                  (vc_c <  CW'(p2_y_q) + CW'(height));
    end

    // Next-state for positions and the delayed pixel stream.
    always_comb begin
        p1_y_d   = p1_y_q;
        p2_y_d   = p2_y_q;
        hcount_d = draw_bg_if.hcount;
        vcount_d = draw_bg_if.vcount;
        hsync_d  = draw_bg_if.hsync;
        hblnk_d  = draw_bg_if.hblnk;
        vsync_d  = draw_bg_if.vsync;
        vblnk_d  = draw_bg_if.vblnk;
        rgb_d    = draw_bg_if.rgb;

        if (vblnk_rise_c && (mode_c != MODE_IDLE)) begin
            p1_y_d = p1_tgt_c;
            p2_y_d = (mode_c == MODE_SINGLE) ? p2_step_c : p2_tgt_c;
        end

        if ((mode_c != MODE_IDLE) && !draw_bg_if.hblnk && !draw_bg_if.vblnk &&
            (in_p1_c || in_p2_c))
            rgb_d = color;
    end

    always_ff @(posedge clk65MHz) begin
        if (rst) begin
            p1_y_q   <= 10'(RST_Y);
            p2_y_q   <= 10'(RST_Y);
            hcount_q <= '0;
            vcount_q <= '0;
            hsync_q  <= 1'b0;
            hblnk_q  <= 1'b0;
            vsync_q  <= 1'b0;
            vblnk_q  <= 1'b0;
            rgb_q    <= '0;
        end else begin
            p1_y_q   <= p1_y_d;
            p2_y_q   <= p2_y_d;
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            hsync_q  <= hsync_d;
            hblnk_q  <= hblnk_d;
            vsync_q  <= vsync_d;
            vblnk_q  <= vblnk_d;
            rgb_q    <= rgb_d;
        end
    end

    assign output_pos          = p1_y_q;
    assign draw_rect_if.hcount = hcount_q;
    assign draw_rect_if.vcount = vcount_q;
    assign draw_rect_if.hsync  = hsync_q;
    assign draw_rect_if.hblnk  = hblnk_q;
    assign draw_rect_if.vsync  = vsync_q;
    assign draw_rect_if.vblnk  = vblnk_q;
    assign draw_rect_if.rgb    = rgb_q;

endmodule

// File: tb/tb_draw_rect_ctl.sv
// Bench for draw_rect_ctl: directed scenarios plus randomized pixel streams
// checked every cycle against a frame-level paddle model.
module tb_draw_rect_ctl;

    localparam int X1 = 32;
    localparam int X2 = 976;
    localparam int W  = 16;
    localparam int H  = 128;
    localparam int MAXY = 768 - H;
    localparam int RSTY = (768 - H) / 2;
    localparam logic [11:0] COL = 12'hFFF;
    localparam logic [11:0] BG  = 12'h123;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] mouse_ypos = '0;
    logic        screen_idle = 1'b1;
    logic        screen_single = 1'b0;
    logic [9:0]  input_pos = 10'd320;
    logic [9:0]  output_pos;

    vga_if bg_if();
    vga_if rect_if();

    draw_rect_ctl dut (
        .clk65MHz     (clk),
        .rst          (rst),
        .mouse_ypos   (mouse_ypos),
        .screen_idle  (screen_idle),
        .screen_single(screen_single),
        .input_pos    (input_pos),
        .output_pos   (output_pos),
        .draw_bg_if   (bg_if),
        .draw_rect_if (rect_if)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model state: paddle tops and previous vblank as seen by the design.
    int  p1_m = RSTY;
    int  p2_m = RSTY;
    bit  prev_vb = 1'b0;

    function automatic int clampy(input int v);
        return (v > MAXY) ? MAXY : v;
    endfunction

    function automatic bit inside_pad(input int hc, input int vc, input int x, input int y);
        return (hc >= x) && (hc < x + W) && (vc >= y) && (vc < y + H);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, predict outputs from the model, compare after the edge.
    task automatic step(input int hc, input int vc, input bit hb, input bit vb,
                        input bit hs, input bit vs, input logic [11:0] rgb);
        logic [25:0] exp_t;
        logic [11:0] exp_rgb;
        int t, d;
        bit idle, single;
        @(negedge clk);
        bg_if.hcount = 11'(hc);
        bg_if.vcount = 11'(vc);
        bg_if.hblnk  = hb;
        bg_if.vblnk  = vb;
        bg_if.hsync  = hs;
        bg_if.vsync  = vs;
        bg_if.rgb    = rgb;
        idle   = screen_idle;
        single = !screen_idle && screen_single;
        if (rst) begin
            exp_t   = '0;
            exp_rgb = '0;
            p1_m    = RSTY;
            p2_m    = RSTY;
            prev_vb = 1'b0;
        end else begin
            exp_t   = {11'(hc), hs, hb, 11'(vc), vs, vb};
            exp_rgb = rgb;
            if (!idle && !hb && !vb &&
                (inside_pad(hc, vc, X1, p1_m) || inside_pad(hc, vc, X2, p2_m)))
                exp_rgb = COL;
            if (vb && !prev_vb && !idle) begin
                p1_m = clampy(int'(mouse_ypos));
                t    = clampy(int'(input_pos));
                if (single) begin
                    d = t - p2_m;
                    if (d > 2) d = 2;
                    if (d < -2) d = -2;
                    p2_m = p2_m + d;
                end else begin
                    p2_m = t;
                end
            end
            prev_vb = vb;
        end
        @(posedge clk);
        #1;
        chk("timing", 32'({rect_if.hcount, rect_if.hsync, rect_if.hblnk,
                           rect_if.vcount, rect_if.vsync, rect_if.vblnk}), 32'(exp_t));
        chk("rgb", 32'(rect_if.rgb), 32'(exp_rgb));
        chk("output_pos", 32'(output_pos), 32'(p1_m));
    endtask

    task automatic pix(input int hc, input int vc, input logic [11:0] want);
        step(hc, vc, 1'b0, 1'b0, 1'b0, 1'b0, BG);
        chk($sformatf("pix(%0d,%0d)", hc, vc), 32'(rect_if.rgb), 32'(want));
    endtask

    // A compressed frame: random active pixels, then a vblank pulse.
    task automatic frame(input int npix, input bit rand_mode);
        int hc;
        for (int i = 0; i < npix; i++) begin
            if (rand_mode && $urandom_range(0, 15) == 0) begin
                screen_idle   = ($urandom_range(0, 3) == 0);
                screen_single = 1'($urandom_range(0, 1));
            end
            case ($urandom_range(0, 2))
                0:       hc = $urandom_range(X1 - 4, X1 + W + 4);
                1:       hc = $urandom_range(X2 - 4, X2 + W + 4);
                default: hc = $urandom_range(0, 1023);
            endcase
            step(hc, $urandom_range(0, 767), ($urandom_range(0, 7) == 0), 1'b0,
                 1'($urandom_range(0, 1)), 1'b0, 12'($urandom));
        end
        for (int i = 0; i < 3; i++)
            step($urandom_range(0, 1343), 768 + i, 1'($urandom_range(0, 1)), 1'b1,
                 1'b0, 1'($urandom_range(0, 1)), 12'($urandom));
        step(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 12'($urandom));
    endtask

    initial begin
        bg_if.hcount = '0; bg_if.vcount = '0; bg_if.hblnk = 1'b0; bg_if.vblnk = 1'b0;
        bg_if.hsync  = 1'b0; bg_if.vsync = 1'b0; bg_if.rgb = '0;

        // Reset for two clocks with non-zero upstream data.
        rst = 1'b1;
        step(100, 200, 1'b1, 1'b1, 1'b1, 1'b1, 12'hABC);
        step(100, 200, 1'b1, 1'b1, 1'b1, 1'b1, 12'hABC);
        chk("rst_rgb", 32'(rect_if.rgb), 32'h0);
        chk("rst_pos", 32'(output_pos), 32'd320);
        rst = 1'b0;

        // IDLE: no overlay, positions frozen.
        screen_idle = 1'b1; screen_single = 1'b0; mouse_ypos = 12'd100;
        frame(20, 1'b0);
        pix(40, 330, BG);
        frame(20, 1'b0);
        chk("idle_pos", 32'(output_pos), 32'd320);

        // SINGLE: p1 follows the mouse at the next vblank rise.
        screen_idle = 1'b0; screen_single = 1'b1; input_pos = 10'd320;
        frame(10, 1'b0);
        chk("single_pos", 32'(output_pos), 32'd100);
        pix(40, 150, COL);
        pix(40, 99, BG);

        // Clamp at the bottom edge.
        mouse_ypos = 12'd700;
        frame(10, 1'b0);
        chk("clamp_pos", 32'(output_pos), 32'd640);
        pix(40, 640, COL);
        pix(40, 767, COL);
        pix(40, 639, BG);
        pix(48, 700, BG);

        // MULTI: p2 jumps straight to the target.
        screen_single = 1'b0; input_pos = 10'd400;
        frame(10, 1'b0);
        pix(976, 400, COL);
        pix(991, 527, COL);
        pix(992, 400, BG);
        pix(975, 400, BG);
        pix(976, 528, BG);
        pix(976, 399, BG);

        // Mid-frame reset, then SINGLE AI approach from 320 at 2 px per frame.
        step(500, 300, 1'b0, 1'b0, 1'b0, 1'b0, BG);
        rst = 1'b1;
        step(500, 301, 1'b0, 1'b0, 1'b0, 1'b0, BG);
        chk("midrst_pos", 32'(output_pos), 32'd320);
        rst = 1'b0;
        screen_single = 1'b1; input_pos = 10'd400; mouse_ypos = 12'd320;
        for (int k = 1; k <= 42; k++) begin
            int y;
            y = (320 + 2 * k > 400) ? 400 : 320 + 2 * k;
            frame(2, 1'b0);
            pix(980, y, COL);
            pix(980, y - 1, BG);
        end

        // Both screen flags set: behaves as IDLE.
        screen_idle = 1'b1; screen_single = 1'b1; mouse_ypos = 12'd10;
        frame(10, 1'b0);
        chk("both_pos", 32'(output_pos), 32'd320);
        pix(40, 330, BG);
        pix(980, 450, BG);

        // Randomized modes, targets and pixel streams.
        for (int f = 0; f < 30; f++) begin
            mouse_ypos    = 12'($urandom_range(0, 4095));
            input_pos     = 10'($urandom);
            screen_idle   = ($urandom_range(0, 3) == 0);
            screen_single = 1'($urandom_range(0, 1));
            frame(60, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
